ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Multi-cycle control unit of the Tiny CPU, directly downstream of the instruction bus splitter.
- Consumes the 4-bit opcode and 8-bit operand produced from the 12-bit instruction word.
- Sequences fetch, decode and execute, and drives the strobes for the IR, PC, accumulator/ALU and data memory.
- Accumulator architecture: one instruction in flight, no pipelining.

Parameters:
OPCODE_W, 4, opcode width (fixed 4; parameter kept for documentation)
DATA_W, 8, operand, address and PC-target width
TRAP_ILLEGAL, 0, 1 = reserved opcode 4'hE halts with illegal_op; 0 = executes as NOP

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
instruction  in  4  opcode from bus splitter, valid in DECODE
data  in  8  operand from bus splitter, valid in DECODE
zero_flag  in  1  accumulator == 0, sampled in EXEC
carry_flag  in  1  carry from last ALU op, sampled in EXEC
ir_load  out  1  load instruction register from instruction memory[PC]
pc_inc  out  1  PC <= PC+1 (wraps 8'hFF -> 8'h00 in PC block)
pc_load  out  1  PC <= pc_target
pc_target  out  8  jump target (= latched operand)
mem_addr  out  8  data-memory address (= latched operand)
mem_rd  out  1  data-memory read strobe
mem_wr  out  1  data-memory write strobe (writes accumulator)
alu_op  out  3  000 passB, 001 add, 010 sub, 011 and, 100 or, 101 notA
alu_src_imm  out  1  1 = ALU B is operand, 0 = B is memory read data
acc_load  out  1  accumulator <= ALU result
halted  out  1  state == HALT
illegal_op  out  1  halted on reserved opcode (TRAP_ILLEGAL=1 only)
state  out  3  current state, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=6. State, op_q, data_q and illegal_q are registers; all outputs decode combinationally from them.
- Reset: async to IDLE; op_q=0, data_q=0, illegal_q=0. All strobes=0, alu_op=000, alu_src_imm=0, pc_target=mem_addr=0, halted=0, illegal_op=0, state=0. Reset mid-instruction drops all strobes immediately.
- IDLE: all strobes 0; run=1 -> FETCH.
- FETCH: ir_load=1 for exactly one cycle -> DECODE.
- DECODE: op_q<=instruction, data_q<=data; no strobes -> EXEC.
- EXEC actions by op_q:
  - 0 NOP: pc_inc.
  - 1 LDI: alu_op=000, alu_src_imm=1, acc_load, pc_inc.
  - 2 LDA, 4 ADD, 5 SUB, 6 AND, 7 OR: mem_rd, mem_addr=data_q -> MEM.
  - 3 STA: mem_wr, pc_inc.
  - 8 ADDI, 9 SUBI: alu_op=001/010, alu_src_imm=1, acc_load, pc_inc.
  - A JMP: pc_load.
  - B JZ: pc_load if zero_flag, else pc_inc.
  - C JC: pc_load if carry_flag, else pc_inc.
  - D NOT: alu_op=101, acc_load, pc_inc.
  - E: NOP, or HALT with illegal_q<=1 when TRAP_ILLEGAL=1.
  - F HLT: -> HALT, no pc_inc.
- MEM: mem_rd held, mem_addr=data_q, alu_src_imm=0, alu_op per opcode (2->000, 4->001, 5->010, 6->011, 7->100), acc_load, pc_inc.
- Exactly one of pc_inc/pc_load per completed instruction; never both in one cycle.
- Next state after EXEC (non-memory, non-halt) or MEM: FETCH if run=1, else IDLE. run is checked only at this boundary; deasserting run mid-instruction completes the instruction.
- Latency: 3 cycles for NOP, LDI, ADDI, SUBI, NOT, STA and jumps; 4 cycles for LDA and ALU-memory ops.
- HALT: all strobes 0, halted=1. Left only by reset; run is ignored.

Test Plan:
- Reset mid-EXEC of ADDI -> acc_load and pc_inc drop to 0 asynchronously, state=0; after release with run=1, FETCH on the first edge.
- run=1, program LDI 8'h05 -> FETCH, DECODE, EXEC; in EXEC alu_op=000, alu_src_imm=1, acc_load=1, pc_inc=1; back in FETCH on cycle 4.
- ADD 8'h20 -> EXEC: mem_rd=1, mem_addr=8'h20; MEM: alu_op=001, alu_src_imm=0, acc_load=1, pc_inc=1; 4 cycles total.
- JZ 8'h3C with zero_flag=1 -> pc_load=1, pc_target=8'h3C, pc_inc=0; with zero_flag=0 -> pc_inc=1, pc_load=0.
- run dropped during DECODE of STA 8'h10 -> EXEC still has mem_wr=1, mem_addr=8'h10, then IDLE with no further ir_load.
- HLT -> halted=1, state=6, strobes 0 for 20 cycles while run toggles. Opcode E with TRAP_ILLEGAL=1 -> halted=1, illegal_op=1; with TRAP_ILLEGAL=0 -> pc_inc=1 only.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit for the Tiny CPU: sequences fetch/decode/execute
// and drives IR, PC, accumulator/ALU and data-memory strobes.
//
// state  | meaning
// IDLE   | waiting for run, no strobes
// FETCH  | ir_load for one cycle
// DECODE | latch opcode and operand
// EXEC   | perform instruction or issue memory read
// MEM    | consume memory read data into accumulator
// HALT   | stopped until reset (HLT or trapped reserved opcode)
module ctrl_sequencer #(
  parameter int OPCODE_W     = 4,
  parameter int DATA_W       = 8,
  parameter bit TRAP_ILLEGAL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] instruction,
  input  logic [DATA_W-1:0]   data,
  input  logic                zero_flag,
  input  logic                carry_flag,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic [DATA_W-1:0]   pc_target,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [2:0]          alu_op,
  output logic                alu_src_imm,
  output logic                acc_load,
  output logic                halted,
  output logic                illegal_op,
  output logic [2:0]          state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_SUBI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_NOTA  = 3'b101;

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                illegal_q, illegal_d;
  logic [2:0]          boundary_state;

  // run is only sampled at an instruction boundary
  assign boundary_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d    = instruction;
        data_d  = data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MEM;
          OP_HLT: state_d = S_HALT;
          OP_RSV: begin
            if (TRAP_ILLEGAL) begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end else begin
              state_d = boundary_state;
            end
          end
          default: state_d = boundary_state;
        endcase
      end
      S_MEM:   state_d = boundary_state;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    alu_op      = ALU_PASSB;
    alu_src_imm = 1'b0;
    acc_load    = 1'b0;
    case (state_q)
      S_FETCH: ir_load = 1'b1;
      S_EXEC: begin
        case (op_q)
          OP_NOP: pc_inc = 1'b1;
          OP_LDI: begin
            alu_op      = ALU_PASSB;
            alu_src_imm = 1'b1;
            acc_load    = 1'b1;
            pc_inc      = 1'b1;
          end
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: mem_rd = 1'b1;
          OP_STA: begin
            mem_wr = 1'b1;
            pc_inc = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            alu_op      = (op_q == OP_ADDI) ? ALU_ADD : ALU_SUB;
            alu_src_imm = 1'b1;
            acc_load    = 1'b1;
            pc_inc      = 1'b1;
          end
          OP_JMP: pc_load = 1'b1;
          OP_JZ: begin
            pc_load = zero_flag;
            pc_inc  = !zero_flag;
          end
          OP_JC: begin
            pc_load = carry_flag;
            pc_inc  = !carry_flag;
          end
          OP_NOT: begin
            alu_op   = ALU_NOTA;
            acc_load = 1'b1;
            pc_inc   = 1'b1;
          end
          OP_RSV: pc_inc = !TRAP_ILLEGAL;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_rd   = 1'b1;
        acc_load = 1'b1;
        pc_inc   = 1'b1;
        case (op_q)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          OP_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_PASSB;
        endcase
      end
      default: ;
    endcase
  end

  assign pc_target  = data_q;
  assign mem_addr   = data_q;
  assign halted     = (state_q == S_HALT);
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer; a second instance with TRAP_ILLEGAL=0
// shares all inputs so the reserved-opcode behaviour is checked both ways.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run, zero_flag, carry_flag;
  logic [3:0] instruction;
  logic [7:0] data;

  logic       t_ir, t_inc, t_ld, t_rd, t_wr, t_acc, t_imm, t_halt, t_ill;
  logic [7:0] t_tgt, t_addr;
  logic [2:0] t_alu, t_st;
  logic       n_ir, n_inc, n_ld, n_rd, n_wr, n_acc, n_imm, n_halt, n_ill;
  logic [7:0] n_tgt, n_addr;
  logic [2:0] n_alu, n_st;

  logic [5:0] strb, strb_n;
  assign strb   = {t_ir, t_inc, t_ld, t_rd, t_wr, t_acc};
  assign strb_n = {n_ir, n_inc, n_ld, n_rd, n_wr, n_acc};

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.OPCODE_W(4), .DATA_W(8), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction), .data(data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .ir_load(t_ir), .pc_inc(t_inc),
    .pc_load(t_ld), .pc_target(t_tgt), .mem_addr(t_addr), .mem_rd(t_rd), .mem_wr(t_wr),
    .alu_op(t_alu), .alu_src_imm(t_imm), .acc_load(t_acc), .halted(t_halt),
    .illegal_op(t_ill), .state(t_st));

  ctrl_sequencer #(.OPCODE_W(4), .DATA_W(8), .TRAP_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction), .data(data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .ir_load(n_ir), .pc_inc(n_inc),
    .pc_load(n_ld), .pc_target(n_tgt), .mem_addr(n_addr), .mem_rd(n_rd), .mem_wr(n_wr),
    .alu_op(n_alu), .alu_src_imm(n_imm), .acc_load(n_acc), .halted(n_halt),
    .illegal_op(n_ill), .state(n_st));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; instruction = 4'h0; data = 8'h00;
    zero_flag = 1'b0; carry_flag = 1'b0;
    #12;
    vecs++;
    if (t_st !== 3'd0 || strb !== 6'b0 || t_alu !== 3'b000 || t_imm !== 1'b0 ||
        t_tgt !== 8'h00 || t_addr !== 8'h00 || t_halt !== 1'b0 || t_ill !== 1'b0) begin
      errs++;
      $display("FAIL reset: state=%0d strb=%b alu=%b imm=%b tgt=%h addr=%h halt=%b ill=%b, expected all zero",
               t_st, strb, t_alu, t_imm, t_tgt, t_addr, t_halt, t_ill);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vecs++;
    if (t_st !== 3'd0 || strb !== 6'b0) begin
      errs++;
      $display("FAIL idle_no_run: state=%0d strb=%b, expected state=0 strb=000000", t_st, strb);
    end
  endtask

  task automatic test_ldi();
    instruction = 4'h1; data = 8'h05; run = 1'b1;
    step();
    vecs++;
    if (t_st !== 3'd1 || strb !== 6'b100000) begin
      errs++;
      $display("FAIL ldi_fetch: state=%0d strb=%b, expected state=1 strb=100000", t_st, strb);
    end
    step();
    vecs++;
    if (t_st !== 3'd2 || strb !== 6'b000000) begin
      errs++;
      $display("FAIL ldi_decode: state=%0d strb=%b, expected state=2 strb=000000", t_st, strb);
    end
    step();
    vecs++;
    if (t_st !== 3'd3 || strb !== 6'b010001 || t_alu !== 3'b000 || t_imm !== 1'b1) begin
      errs++;
      $display("FAIL ldi_exec: state=%0d strb=%b alu=%b imm=%b, expected state=3 strb=010001 alu=000 imm=1",
               t_st, strb, t_alu, t_imm);
    end
    step();
    vecs++;
    if (t_st !== 3'd1 || strb !== 6'b100000) begin
      errs++;
      $display("FAIL ldi_refetch: state=%0d strb=%b, expected state=1 strb=100000", t_st, strb);
    end
  endtask

  task automatic test_mem_ops();
    logic [3:0] opc [5];
    logic [2:0] aop [5];
    opc = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h7};
    aop = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 5; i++) begin
      instruction = opc[i]; data = 8'h20 + 8'(i);
      step();
      step();
      vecs++;
      if (t_st !== 3'd3 || strb !== 6'b000100 || t_addr !== 8'h20 + 8'(i)) begin
        errs++;
        $display("FAIL mem_exec op=%h: state=%0d strb=%b addr=%h, expected state=3 strb=000100 addr=%h",
                 opc[i], t_st, strb, t_addr, 8'h20 + 8'(i));
      end
      step();
      vecs++;
      if (t_st !== 3'd4 || strb !== 6'b010101 || t_alu !== aop[i] || t_imm !== 1'b0 ||
          t_addr !== 8'h20 + 8'(i)) begin
        errs++;
        $display("FAIL mem_mem op=%h: state=%0d strb=%b alu=%b imm=%b addr=%h, expected state=4 strb=010101 alu=%b imm=0",
                 opc[i], t_st, strb, t_alu, t_imm, t_addr, aop[i]);
      end
      step();
      vecs++;
      if (t_st !== 3'd1 || strb !== 6'b100000) begin
        errs++;
        $display("FAIL mem_refetch op=%h: state=%0d strb=%b, expected state=1 strb=100000",
                 opc[i], t_st, strb);
      end
    end
  endtask

  task automatic test_jumps();
    instruction = 4'hB; data = 8'h3C; zero_flag = 1'b1;
    step(); step();
    vecs++;
    if (strb !== 6'b001000 || t_tgt !== 8'h3C) begin
      errs++;
      $display("FAIL jz_taken: strb=%b tgt=%h, expected strb=001000 tgt=3c", strb, t_tgt);
    end
    step();
    zero_flag = 1'b0;
    step(); step();
    vecs++;
    if (strb !== 6'b010000) begin
      errs++;
      $display("FAIL jz_not_taken: strb=%b, expected 010000", strb);
    end
    step();
    instruction = 4'hC; data = 8'h81; carry_flag = 1'b1;
    step(); step();
    vecs++;
    if (strb !== 6'b001000 || t_tgt !== 8'h81) begin
      errs++;
      $display("FAIL jc_taken: strb=%b tgt=%h, expected strb=001000 tgt=81", strb, t_tgt);
    end
    carry_flag = 1'b0;
    vecs++;
    #1;
    if (strb !== 6'b010000) begin
      errs++;
      $display("FAIL jc_not_taken: strb=%b, expected 010000", strb);
    end
    step();
    instruction = 4'hD; data = 8'h00;
    step(); step();
    vecs++;
    if (strb !== 6'b010001 || t_alu !== 3'b101 || t_imm !== 1'b0) begin
      errs++;
      $display("FAIL not_exec: strb=%b alu=%b imm=%b, expected strb=010001 alu=101 imm=0",
               strb, t_alu, t_imm);
    end
    step();
  endtask

  task automatic test_run_drop();
    instruction = 4'h3; data = 8'h10;
    step();
    run = 1'b0;
    step();
    vecs++;
    if (t_st !== 3'd3 || strb !== 6'b010010 || t_addr !== 8'h10) begin
      errs++;
      $display("FAIL sta_exec: state=%0d strb=%b addr=%h, expected state=3 strb=010010 addr=10",
               t_st, strb, t_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (t_st !== 3'd0 || strb !== 6'b000000) begin
        errs++;
        $display("FAIL run_drop_idle[%0d]: state=%0d strb=%b, expected state=0 strb=000000",
                 i, t_st, strb);
      end
    end
  endtask

  task automatic test_reset_mid();
    instruction = 4'h8; data = 8'h03; run = 1'b1;
    step(); step(); step();
    vecs++;
    if (t_st !== 3'd3 || strb !== 6'b010001 || t_alu !== 3'b001 || t_imm !== 1'b1) begin
      errs++;
      $display("FAIL addi_exec: state=%0d strb=%b alu=%b imm=%b, expected state=3 strb=010001 alu=001 imm=1",
               t_st, strb, t_alu, t_imm);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (t_st !== 3'd0 || strb !== 6'b000000 || t_alu !== 3'b000) begin
      errs++;
      $display("FAIL async_reset: state=%0d strb=%b alu=%b, expected state=0 strb=000000 alu=000",
               t_st, strb, t_alu);
    end
    #1;
    rst_n = 1'b1;
    step();
    vecs++;
    if (t_st !== 3'd1 || strb !== 6'b100000) begin
      errs++;
      $display("FAIL post_reset_fetch: state=%0d strb=%b, expected state=1 strb=100000", t_st, strb);
    end
  endtask

  task automatic test_halt();
    instruction = 4'hF; data = 8'h55;
    step(); step();
    vecs++;
    if (t_st !== 3'd3 || strb !== 6'b000000) begin
      errs++;
      $display("FAIL hlt_exec: state=%0d strb=%b, expected state=3 strb=000000", t_st, strb);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      run = i[0];
      vecs++;
      if (t_st !== 3'd6 || strb !== 6'b000000 || t_halt !== 1'b1 || t_ill !== 1'b0) begin
        errs++;
        $display("FAIL halt_hold[%0d]: state=%0d strb=%b halt=%b ill=%b, expected state=6 strb=000000 halt=1 ill=0",
                 i, t_st, strb, t_halt, t_ill);
      end
    end
  endtask

  task automatic test_illegal();
    rst_n = 1'b0; run = 1'b0;
    #2;
    rst_n = 1'b1;
    instruction = 4'hE; data = 8'h77; run = 1'b1;
    step(); step(); step();
    vecs++;
    if (strb !== 6'b000000 || strb_n !== 6'b010000) begin
      errs++;
      $display("FAIL rsv_exec: trap strb=%b nontrap strb=%b, expected trap 000000 nontrap 010000",
               strb, strb_n);
    end
    step();
    vecs++;
    if (t_st !== 3'd6 || t_halt !== 1'b1 || t_ill !== 1'b1) begin
      errs++;
      $display("FAIL rsv_trap: state=%0d halt=%b ill=%b, expected state=6 halt=1 ill=1",
               t_st, t_halt, t_ill);
    end
    vecs++;
    if (n_st !== 3'd1 || n_halt !== 1'b0 || n_ill !== 1'b0) begin
      errs++;
      $display("FAIL rsv_nop: state=%0d halt=%b ill=%b, expected state=1 halt=0 ill=0",
               n_st, n_halt, n_ill);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mem_ops();
    test_jumps();
    test_run_drop();
    test_reset_mid();
    test_halt();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
